// File: rtl/median_result_writer.sv
// Result-frame writer: buffers filtered pixels in a small FIFO and writes them to RAM port A
// whenever the port is granted, counting one frame and pulsing frame_done once it is committed.
module median_result_writer #(
  parameter int LENGTH     = 480,
  parameter int WIDTH      = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  input  logic [18:0] pix_addr,
  output logic        pix_ready,
  input  logic        wr_grant,
  output logic        ram_wren,
  output logic [18:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        busy,
  output logic        frame_done,
  output logic [18:0] pix_count,
  output logic        addr_err
);

  localparam int               FRAME_PIXELS = LENGTH * WIDTH;
  localparam logic [18:0]      FRAME_PIX    = 19'(FRAME_PIXELS);
  localparam int               PTR_W        = $clog2(FIFO_DEPTH);
  localparam int               OCC_W        = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC     = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [18:0]        cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic [26:0]        mem_q [FIFO_DEPTH];
  logic               ram_wren_q;
  logic [18:0]        ram_addr_q;
  logic [7:0]         ram_data_q;

  logic hs, addr_ok, push, pop, fifo_full;

  function automatic logic [18:0] sat_inc(input logic [18:0] v);
    return (v >= FRAME_PIX) ? FRAME_PIX : v + 19'd1;
  endfunction

  assign fifo_full = (occ_q == FULL_OCC);
  assign pix_ready = (state_q == ACTIVE) && !fifo_full;
  assign hs        = pix_valid && pix_ready;
  assign addr_ok   = (pix_addr < FRAME_PIX);
  // Out-of-range addresses are counted toward the frame but never reach the RAM.
  assign push      = hs && addr_ok;
  assign pop       = (occ_q != '0) && wr_grant;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (hs) begin
          cnt_d = sat_inc(cnt_q);
          if (!addr_ok) err_d = 1'b1;
          if (cnt_q == FRAME_PIX - 19'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (occ_q == '0 && !ram_wren_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {pix_addr, pix_data};
  end

  // RAM strobe is registered; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wren_q <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      ram_wren_q <= pop;
      if (pop) {ram_addr_q, ram_data_q} <= mem_q[rptr_q];
    end
  end

  assign ram_wren   = ram_wren_q;
  assign ram_addr   = ram_addr_q;
  assign ram_data   = ram_data_q;
  assign busy       = (state_q == ACTIVE) || (state_q == DRAIN);
  assign frame_done = (state_q == DONE);
  assign pix_count  = cnt_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_median_result_writer.sv
// Bench for median_result_writer on a reduced 8x4 frame: table-driven pixels, hand-written
// stall/reset/frame sequences, and a scoreboard checking every RAM write in order.
module tb_median_result_writer;

  localparam int LENGTH = 8;
  localparam int WIDTH  = 4;
  localparam int FP     = LENGTH * WIDTH;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, wr_grant;
  logic [7:0]  pix_data;
  logic [18:0] pix_addr;
  logic        pix_ready, ram_wren, busy, frame_done, addr_err;
  logic [18:0] ram_addr, pix_count;
  logic [7:0]  ram_data;

  median_result_writer #(.LENGTH(LENGTH), .WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_addr(pix_addr), .pix_ready(pix_ready), .wr_grant(wr_grant), .ram_wren(ram_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .frame_done(frame_done),
    .pix_count(pix_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [18:0] a; logic [7:0] d;} ent_t;
  typedef struct {logic [7:0] d; logic [18:0] a; logic [18:0] exp_cnt; logic exp_err;} vec_t;

  ent_t sb[$];
  ent_t e;
  int   total = 0, bad = 0, wr_cnt = 0, cyc = 0;
  int   first_hs = -1, first_wr = -1;
  bit   rand_grant = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: writes are checked against the scoreboard; accepted in-range pixels are queued.
  always @(negedge clk) begin
    if (ram_wren) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", ram_addr, ram_data);
      end else begin
        e = sb.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          bad++;
          $display("FAIL write_order: got addr=%0d data=%0h expected addr=%0d data=%0h",
                   ram_addr, ram_data, e.a, e.d);
        end
      end
    end
    if (rst) sb.delete();
    else if (pix_valid && pix_ready) begin
      if (first_hs < 0) first_hs = cyc;
      if (pix_addr < 19'(FP)) sb.push_back({pix_addr, pix_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_grant) wr_grant = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered and left at posedge+1; returns just after the handshake edge.
  task automatic send(input logic [7:0] d, input logic [18:0] a);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_addr  = a;
    @(negedge clk);
    while (!pix_ready && n < 200) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!pix_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got pix_ready=0 expected 1 within 200 cycles");
    end
    tick();
    pix_valid = 1'b0;
  endtask

  vec_t tbl[6];
  int   w0, n;

  initial begin
    tbl[0] = '{8'h10, 19'd0, 19'd1, 1'b0};
    tbl[1] = '{8'h11, 19'd1, 19'd2, 1'b0};
    tbl[2] = '{8'h12, 19'd2, 19'd3, 1'b0};
    tbl[3] = '{8'h13, 19'd3, 19'd4, 1'b0};
    tbl[4] = '{8'h14, 19'd4, 19'd5, 1'b0};
    tbl[5] = '{8'h77, 19'(FP), 19'd6, 1'b1};

    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_addr = '0; wr_grant = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wren", ram_wren, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_count", pix_count, 0);
    chk("rst_err", addr_err, 0);

    // Basic stream plus one out-of-range address
    wr_grant = 1'b1;
    first_hs = -1; first_wr = -1;
    w0 = wr_cnt;
    pulse_start();
    chk("start_busy", busy, 1);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].a);
      chk($sformatf("tbl_count_%0d", i), pix_count, tbl[i].exp_cnt);
      chk($sformatf("tbl_err_%0d", i), addr_err, tbl[i].exp_err);
    end
    repeat (6) tick();
    chk("tbl_writes", wr_cnt - w0, 5);
    chk("first_latency", first_wr - first_hs, 2);

    // Reset with three entries queued
    wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) send(8'h30 + 8'(i), 19'(10 + i));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstq_wren", ram_wren, 0);
    chk("rstq_ready", pix_ready, 0);
    chk("rstq_busy", busy, 0);
    chk("rstq_count", pix_count, 0);
    w0 = wr_cnt;
    wr_grant = 1'b1;
    repeat (5) tick();
    pulse_start();
    repeat (5) tick();
    chk("rstq_no_residual", wr_cnt - w0, 0);

    // Stall with wr_grant low: FIFO fills, no bypass while full
    wr_grant = 1'b0;
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 19'(20 + i));
    pix_valid = 1'b1; pix_data = 8'h44; pix_addr = 19'd24;
    @(negedge clk);
    chk("ready_full", pix_ready, 0);
    @(posedge clk); #1;
    wr_grant = 1'b1;
    @(negedge clk);
    chk("no_bypass", pix_ready, 0);
    tick();
    send(8'h44, 19'd24);
    send(8'h45, 19'd25);
    repeat (8) tick();
    chk("stall_writes", wr_cnt - w0, 6);
    chk("stall_count", pix_count, 6);

    // start during ACTIVE is ignored
    send(8'h46, 19'd26);
    pulse_start();
    chk("start_ignored_cnt", pix_count, 7);
    chk("start_ignored_busy", busy, 1);
    send(8'h47, 19'd27);
    chk("start_ignored_cnt2", pix_count, 8);

    // Full frame with random grant and one bad address
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    w0 = wr_cnt;
    rand_grant = 1;
    for (int i = 0; i < FP; i++)
      send(8'($urandom), (i == 10) ? 19'(FP + 3) : 19'(i));
    chk("frame_drain_busy", busy, 1);
    n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    tick();
    chk("frame_done_1cyc", frame_done, 0);
    chk("frame_busy_after", busy, 0);
    chk("frame_writes", wr_cnt - w0, FP - 1);
    chk("frame_err", addr_err, 1);
    chk("frame_count_hold", pix_count, FP);
    chk("frame_sb_empty", sb.size(), 0);
    rand_grant = 0;
    pulse_start();
    chk("restart_err_clr", addr_err, 0);
    chk("restart_count_clr", pix_count, 0);
    chk("restart_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
